// File: rtl/lcd_capture_pkg.sv
// lcd_capture_pkg: default LCD geometry and capture FSM states shared by the
// capture block and its geometry checker.
package lcd_capture_pkg;
    localparam int H_LINE_DEF = 480;
    localparam int V_LINE_DEF = 272;
    localparam int ADDR_W     = 17;
    localparam int COORD_W    = 11;
    typedef enum logic [1:0] {WAIT_VS, IDLE, ACTIVE} cap_state_t;
endpackage

// File: rtl/lcd_capture_geom_check.sv
// lcd_geom_check: line-length and line-count checks plus the good-frame lock counter.
module lcd_geom_check
    import lcd_capture_pkg::*;
#(
    parameter int H_LINE      = H_LINE_DEF,
    parameter int V_LINE      = V_LINE_DEF,
    parameter int LOCK_FRAMES = 2
) (
    input  logic               clk,
    input  logic               rest_n,
    input  logic               line_end,
    input  logic               frame_edge,
    input  logic               frame_open,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output logic               line_err,
    output logic               frame_err,
    output logic               locked
);
    logic [7:0] good_cnt, good_cnt_nx;
    logic       bad, bad_nx, l_err, f_err;

    assign l_err = line_end && (x != COORD_W'(H_LINE));
    assign f_err = frame_edge && frame_open && (y != COORD_W'(V_LINE));

    // bad remembers a line error until the vsync edge that closes its frame
    always_comb begin
        good_cnt_nx = l_err ? 8'd0 : good_cnt;
        bad_nx      = bad | l_err;
        if (frame_edge) begin
            bad_nx = 1'b0;
            if (frame_open)
                good_cnt_nx = (bad || f_err) ? 8'd0
                            : good_cnt + {7'd0, good_cnt < 8'(LOCK_FRAMES)};
        end
    end

    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            good_cnt  <= '0;
            bad       <= 1'b0;
            line_err  <= 1'b0;
            frame_err <= 1'b0;
            locked    <= 1'b0;
        end else begin
            good_cnt  <= good_cnt_nx;
            bad       <= bad_nx;
            line_err  <= l_err;
            frame_err <= f_err;
            locked    <= good_cnt_nx >= 8'(LOCK_FRAMES);
        end
    end
endmodule

// File: rtl/lcd_capture.sv
// lcd_capture: parallel RGB LCD receiver; rebuilds pixel coordinates and writes
// active pixels into a row-major frame memory (addr = y*H_LINE + x).
module lcd_capture
    import lcd_capture_pkg::*;
#(
    parameter int H_LINE          = H_LINE_DEF,
    parameter int V_LINE          = V_LINE_DEF,
    parameter bit SYNC_ACTIVE_LOW = 1'b1,
    parameter int LOCK_FRAMES     = 2
) (
    input  logic               clk,
    input  logic               rest_n,
    input  logic               in_hsync,
    input  logic               in_vsync,
    input  logic               in_de,
    input  logic [7:0]         in_pixel,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [7:0]         wr_data,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y,
    output logic               frame_start,
    output logic               frame_done,
    output logic               line_err,
    output logic               frame_err,
    output logic               locked
);
    cap_state_t         state, state_nx;
    logic               hs1, vs1, de1, vs_prev, vs_act, vs_edge;
    logic [7:0]         px1;
    logic [COORD_W-1:0] x, x_nx, y, y_nx;
    logic [ADDR_W-1:0]  line_base, line_base_nx;
    logic               wr, line_end, done;
    logic               unused_hsync;

    assign unused_hsync = hs1;
    assign vs_act       = vs1 ^ SYNC_ACTIVE_LOW;
    assign vs_edge      = vs_act & ~vs_prev;

    // sync registers reset to their inactive level so reset release is not a frame edge
    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            hs1     <= SYNC_ACTIVE_LOW;
            vs1     <= SYNC_ACTIVE_LOW;
            de1     <= 1'b0;
            px1     <= '0;
            vs_prev <= 1'b0;
        end else begin
            hs1     <= in_hsync;
            vs1     <= in_vsync;
            de1     <= in_de;
            px1     <= in_pixel;
            vs_prev <= vs_act;
        end
    end

    always_comb begin
        state_nx     = state;
        x_nx         = x;
        y_nx         = y;
        line_base_nx = line_base;
        wr           = 1'b0;
        line_end     = 1'b0;
        done         = 1'b0;
        if (vs_edge) begin
            state_nx     = IDLE;
            x_nx         = '0;
            y_nx         = '0;
            line_base_nx = '0;
        end else if (state != WAIT_VS && de1) begin
            state_nx = ACTIVE;
            wr       = (x < COORD_W'(H_LINE)) && (y < COORD_W'(V_LINE));
            x_nx     = x + {{(COORD_W-1){1'b0}}, x != '1};
        end else if (state == ACTIVE) begin
            state_nx     = IDLE;
            line_end     = 1'b1;
            x_nx         = '0;
            y_nx         = y + {{(COORD_W-1){1'b0}}, y != '1};
            line_base_nx = line_base + ((y < COORD_W'(V_LINE)) ? ADDR_W'(H_LINE) : '0);
            done         = y == COORD_W'(V_LINE - 1);
        end
    end

    always_ff @(posedge clk or negedge rest_n) begin
        if (!rest_n) begin
            state       <= WAIT_VS;
            x           <= '0;
            y           <= '0;
            line_base   <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            o_x         <= '0;
            o_y         <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state       <= state_nx;
            x           <= x_nx;
            y           <= y_nx;
            line_base   <= line_base_nx;
            wr_en       <= wr;
            frame_start <= vs_edge;
            frame_done  <= done;
            if (wr) begin
                wr_addr <= line_base + ADDR_W'(x);
                wr_data <= px1;
                o_x     <= x;
                o_y     <= y;
            end
        end
    end

    lcd_geom_check #(
        .H_LINE      (H_LINE),
        .V_LINE      (V_LINE),
        .LOCK_FRAMES (LOCK_FRAMES)
    ) u_geom (
        .clk        (clk),
        .rest_n     (rest_n),
        .line_end   (line_end),
        .frame_edge (vs_edge),
        .frame_open (state != WAIT_VS),
        .x          (x),
        .y          (y),
        .line_err   (line_err),
        .frame_err  (frame_err),
        .locked     (locked)
    );
endmodule

// File: tb/tb_lcd_capture.sv
// tb_lcd_capture: directed checks of lcd_capture on a reduced 20x10 geometry.
module tb_lcd_capture;
    localparam int   H = 20;
    localparam int   V = 10;
    localparam logic VS_ON = 1'b0;
    localparam logic VS_OFF = 1'b1;

    logic        clk = 1'b0;
    logic        rest_n = 1'b0;
    logic        in_hsync = 1'b1, in_vsync = 1'b1, in_de = 1'b0;
    logic [7:0]  in_pixel = '0;
    logic        wr_en, frame_start, frame_done, line_err, frame_err, locked;
    logic [16:0] wr_addr;
    logic [7:0]  wr_data;
    logic [10:0] o_x, o_y;

    int vecs = 0, errs = 0;
    int wr_count, gaps, fs_cnt, fd_cnt, le_cnt, fe_cnt, first_addr, last_addr, first6, max_x, last_y;
    logic [8:0] mem [0:255];

    lcd_capture #(.H_LINE(H), .V_LINE(V), .SYNC_ACTIVE_LOW(1'b1), .LOCK_FRAMES(2)) dut (
        .clk(clk), .rest_n(rest_n), .in_hsync(in_hsync), .in_vsync(in_vsync),
        .in_de(in_de), .in_pixel(in_pixel), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .o_x(o_x), .o_y(o_y), .frame_start(frame_start),
        .frame_done(frame_done), .line_err(line_err), .frame_err(frame_err), .locked(locked)
    );

    always #5 clk = ~clk;

    // collects writes and pulses away from the active edge
    always @(negedge clk) begin
        if (rest_n) begin
            if (wr_en) begin
                if (wr_count > 0 && int'(wr_addr) != last_addr + 1) gaps++;
                if (wr_count == 0) first_addr = int'(wr_addr);
                if (o_y == 11'd6 && first6 < 0) first6 = int'(wr_addr);
                if (int'(o_x) > max_x) max_x = int'(o_x);
                if (wr_addr < 17'd256) mem[wr_addr[7:0]] = {1'b1, wr_data};
                last_addr = int'(wr_addr);
                last_y = int'(o_y);
                wr_count++;
            end
            fs_cnt += int'(frame_start);
            fd_cnt += int'(frame_done);
            le_cnt += int'(line_err);
            fe_cnt += int'(frame_err);
        end
    end

    task automatic clr();
        wr_count = 0; gaps = 0; fs_cnt = 0; fd_cnt = 0; le_cnt = 0; fe_cnt = 0;
        first_addr = -1; last_addr = -1; first6 = -1; max_x = -1; last_y = -1;
        for (int i = 0; i < 256; i++) mem[i] = '0;
    endtask

    task automatic step(input logic vs, input logic de, input logic [7:0] px);
        in_vsync = vs;
        in_de = de;
        in_pixel = px;
        @(posedge clk);
        #1;
    endtask

    task automatic send_line(input int n);
        for (int i = 0; i < n; i++) step(VS_OFF, 1'b1, 8'(i));
        in_hsync = 1'b0;
        repeat (2) step(VS_OFF, 1'b0, 8'd0);
        in_hsync = 1'b1;
        repeat (2) step(VS_OFF, 1'b0, 8'd0);
    endtask

    task automatic vsync_pulse();
        repeat (3) step(VS_ON, 1'b0, 8'd0);
        repeat (3) step(VS_OFF, 1'b0, 8'd0);
    endtask

    task automatic send_lines(input int n, input int bad_y, input int bad_len);
        for (int y = 0; y < n; y++) send_line(y == bad_y ? bad_len : H);
    endtask

    task automatic flush();
        repeat (3) step(VS_OFF, 1'b0, 8'd0);
    endtask

    task automatic test_reset();
        clr();
        repeat (2) @(posedge clk);
        #1;
        vecs++; if ({wr_en, wr_addr, wr_data, o_x, o_y} !== '0) begin errs++; $display("FAIL reset_write_outs: got %h exp 0", {wr_en, wr_addr, wr_data, o_x, o_y}); end
        vecs++; if ({frame_start, frame_done, line_err, frame_err, locked} !== 5'b0) begin errs++; $display("FAIL reset_flags: got %b exp 00000", {frame_start, frame_done, line_err, frame_err, locked}); end
        rest_n = 1'b1;
        send_lines(2, -1, 0);
        flush();
        vecs++; if (wr_count !== 0) begin errs++; $display("FAIL reset_no_vsync_writes: got %0d exp 0", wr_count); end
    endtask

    task automatic test_nominal();
        clr();
        repeat (3) step(VS_ON, 1'b0, 8'd0);
        step(VS_OFF, 1'b0, 8'd0);
        vecs++; if (fs_cnt !== 1) begin errs++; $display("FAIL nom_frame_start: got %0d exp 1", fs_cnt); end
        repeat (2) step(VS_OFF, 1'b0, 8'd0);
        send_lines(V, -1, 0);
        flush();
        vecs++; if (wr_count !== 200) begin errs++; $display("FAIL nom_wr_count: got %0d exp 200", wr_count); end
        vecs++; if (gaps !== 0) begin errs++; $display("FAIL nom_addr_gaps: got %0d exp 0", gaps); end
        vecs++; if (first_addr !== 0) begin errs++; $display("FAIL nom_first_addr: got %0d exp 0", first_addr); end
        vecs++; if (last_addr !== 199) begin errs++; $display("FAIL nom_last_addr: got %0d exp 199", last_addr); end
        vecs++; if (mem[20] !== 9'h100) begin errs++; $display("FAIL nom_data_20: got %h exp 100", mem[20]); end
        vecs++; if (mem[199] !== 9'h113) begin errs++; $display("FAIL nom_data_199: got %h exp 113", mem[199]); end
        vecs++; if (max_x !== 19 || last_y !== 9) begin errs++; $display("FAIL nom_coords: got x%0d y%0d exp x19 y9", max_x, last_y); end
        vecs++; if (fd_cnt !== 1) begin errs++; $display("FAIL nom_frame_done: got %0d exp 1", fd_cnt); end
        vecs++; if (le_cnt !== 0 || fe_cnt !== 0) begin errs++; $display("FAIL nom_errors: got le%0d fe%0d exp 0 0", le_cnt, fe_cnt); end
        vecs++; if (locked !== 1'b0) begin errs++; $display("FAIL nom_not_locked: got %b exp 0", locked); end
    endtask

    task automatic test_lock_acquire();
        vsync_pulse();
        send_lines(V, -1, 0);
        vecs++; if (locked !== 1'b0) begin errs++; $display("FAIL lock_after_one: got %b exp 0", locked); end
        vsync_pulse();
        vecs++; if (locked !== 1'b1) begin errs++; $display("FAIL lock_after_two: got %b exp 1", locked); end
        send_lines(V, -1, 0);
    endtask

    task automatic test_short_line();
        clr();
        vsync_pulse();
        send_lines(V, 5, H - 1);
        flush();
        vecs++; if (le_cnt !== 1) begin errs++; $display("FAIL short_line_err: got %0d exp 1", le_cnt); end
        vecs++; if (first6 !== 120) begin errs++; $display("FAIL short_line6_addr: got %0d exp 120", first6); end
        vecs++; if (mem[119] !== 9'h000 || mem[118] !== 9'h112) begin errs++; $display("FAIL short_line5_tail: got %h %h exp 112 000", mem[118], mem[119]); end
        vecs++; if (wr_count !== 199) begin errs++; $display("FAIL short_wr_count: got %0d exp 199", wr_count); end
        vecs++; if (locked !== 1'b0) begin errs++; $display("FAIL short_lock_drop: got %b exp 0", locked); end
    endtask

    task automatic test_long_line();
        clr();
        vsync_pulse();
        send_lines(V, 5, H + 1);
        flush();
        vecs++; if (fe_cnt !== 0) begin errs++; $display("FAIL long_no_frame_err: got %0d exp 0", fe_cnt); end
        vecs++; if (le_cnt !== 1) begin errs++; $display("FAIL long_line_err: got %0d exp 1", le_cnt); end
        vecs++; if (wr_count !== 200 || max_x !== 19) begin errs++; $display("FAIL long_overrun_written: got n%0d x%0d exp n200 x19", wr_count, max_x); end
        vecs++; if (first6 !== 120 || gaps !== 0) begin errs++; $display("FAIL long_line6_addr: got %0d gaps %0d exp 120 0", first6, gaps); end
        vecs++; if (mem[119] !== 9'h113) begin errs++; $display("FAIL long_data_119: got %h exp 113", mem[119]); end
    endtask

    task automatic test_frame_err();
        vsync_pulse();
        send_lines(V, -1, 0);
        vsync_pulse();
        send_lines(V, -1, 0);
        vsync_pulse();
        vecs++; if (locked !== 1'b1) begin errs++; $display("FAIL ferr_relock: got %b exp 1", locked); end
        send_lines(V - 1, -1, 0);
        clr();
        vsync_pulse();
        vecs++; if (fe_cnt !== 1 || le_cnt !== 0) begin errs++; $display("FAIL ferr_pulse: got fe%0d le%0d exp 1 0", fe_cnt, le_cnt); end
        vecs++; if (locked !== 1'b0) begin errs++; $display("FAIL ferr_lock_drop: got %b exp 0", locked); end
        send_lines(V, -1, 0);
        vsync_pulse();
        vecs++; if (locked !== 1'b0) begin errs++; $display("FAIL ferr_one_good: got %b exp 0", locked); end
        send_lines(V, -1, 0);
        vsync_pulse();
        vecs++; if (locked !== 1'b1) begin errs++; $display("FAIL ferr_two_good: got %b exp 1", locked); end
        vecs++; if (fe_cnt !== 1) begin errs++; $display("FAIL ferr_single: got %0d exp 1", fe_cnt); end
    endtask

    task automatic test_coincident();
        clr();
        step(VS_ON, 1'b1, 8'hAA);
        vecs++; if (frame_start !== 1'b0) begin errs++; $display("FAIL coin_fs_early: got %b exp 0", frame_start); end
        step(VS_OFF, 1'b1, 8'd0);
        vecs++; if (frame_start !== 1'b1 || wr_en !== 1'b0) begin errs++; $display("FAIL coin_fs_nowrite: got fs%b wr%b exp 1 0", frame_start, wr_en); end
        step(VS_OFF, 1'b1, 8'd1);
        vecs++; if (wr_en !== 1'b1 || wr_addr !== 17'd0 || wr_data !== 8'd0) begin errs++; $display("FAIL coin_first_write: got en%b a%0d d%h exp 1 0 00", wr_en, wr_addr, wr_data); end
        for (int i = 2; i < H; i++) step(VS_OFF, 1'b1, 8'(i));
        flush();
        vecs++; if (wr_count !== H || le_cnt !== 0 || mem[0] !== 9'h100) begin errs++; $display("FAIL coin_line: got n%0d le%0d m0 %h exp 20 0 100", wr_count, le_cnt, mem[0]); end
    endtask

    task automatic test_reset_mid();
        send_lines(4, -1, 0);
        for (int i = 0; i < 7; i++) step(VS_OFF, 1'b1, 8'(i));
        #2 rest_n = 1'b0;
        #2;
        vecs++; if ({wr_en, wr_addr, wr_data, o_x, o_y, frame_start, frame_done, line_err, frame_err, locked} !== '0) begin errs++; $display("FAIL midreset_outs: got en%b a%0d lk%b exp all 0", wr_en, wr_addr, locked); end
        for (int i = 7; i < 10; i++) step(VS_OFF, 1'b1, 8'(i));
        rest_n = 1'b1;
        clr();
        for (int i = 10; i < H; i++) step(VS_OFF, 1'b1, 8'(i));
        repeat (2) step(VS_OFF, 1'b0, 8'd0);
        send_lines(3, -1, 0);
        flush();
        vecs++; if (wr_count !== 0) begin errs++; $display("FAIL midreset_no_writes: got %0d exp 0", wr_count); end
        vsync_pulse();
        send_lines(V, -1, 0);
        flush();
        vecs++; if (first_addr !== 0 || wr_count !== 200 || fe_cnt !== 0) begin errs++; $display("FAIL midreset_recover: got a%0d n%0d fe%0d exp 0 200 0", first_addr, wr_count, fe_cnt); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_lock_acquire();
        test_short_line();
        test_long_line();
        test_frame_err();
        test_coincident();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
